matmul_result_drain: RTL and testbench

Sequential consumer for the combinational matrix multiply-accumulate datapath. Captures one full M×N result matrix of signed 4P-bit accumulators on a valid/ready handshake. Streams the matrix out one row per beat over a second valid/ready interface, with a last flag on the final row. Sits between the MAC array output and the write-back/memory path, decoupling the wide parallel result from the narrower row bus.

---
 rtl/mma_pkg.sv | 42 ++++
 rtl/mma_row_sat.sv | 35 +++
 rtl/matmul_result_drain.sv | 129 ++++++++++++
 tb/tb_matmul_result_drain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mma_pkg
// Description : Shared types and constants for the matmul result drain.
//               It holds the FSM state encoding, the default M/N/P sizes and
//               a shift+saturate helper for the default precision.
// Revision    : 1.0 - initial release
// ============================================================================
package mma_pkg;

    // Default geometry and operand precision
    localparam int c_m = 4;
    localparam int c_n = 4;
    localparam int c_p = 8;

    // Drain FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t c_idle  = 1'b0;
    localparam state_t c_drain = 1'b1;

    // Saturation bounds, expressed at accumulator width
    localparam logic signed [4*c_p-1:0] c_acc_max = (4*c_p)'(2**(c_p-1) - 1);
    localparam logic signed [4*c_p-1:0] c_acc_min = (4*c_p)'(-(2**(c_p-1)));

    // Arithmetic right shift followed by saturation to c_p signed bits
    function automatic logic signed [c_p-1:0] sat_shift(
        input logic signed [4*c_p-1:0] value,
        input int unsigned             shift
    );
        logic signed [4*c_p-1:0] v;
        v = value >>> shift;
        if (v > c_acc_max) begin
            sat_shift = c_acc_max[c_p-1:0];
        end else if (v < c_acc_min) begin
            sat_shift = c_acc_min[c_p-1:0];
        end else begin
            sat_shift = v[c_p-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mma_row_sat.sv
`default_nettype none
// ============================================================================
// Module      : mma_row_sat
// Description : Single-element arithmetic right shift by SHIFT followed by
//               saturation from 4*P signed bits down to P signed bits.
//               Instantiated per column when MMA_DRAIN_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mma_row_sat
    import mma_pkg::*;
#(
    parameter int P     = c_p,
    parameter int SHIFT = 0
) (
    input  logic signed [4*P-1:0] i_value,
    output logic signed [P-1:0]   o_value
);

    logic signed [4*P-1:0] w_shifted;
    logic [3*P:0]          w_upper;
    logic                  w_fits;

    assign w_shifted = i_value >>> SHIFT;

    // The value fits in P bits when every bit above the P-bit sign bit
    // matches it, i.e. the top 3*P+1 bits are all zeros or all ones.
    assign w_upper = w_shifted[4*P-1:P-1];
    assign w_fits  = (&w_upper) | ~(|w_upper);

    assign o_value = w_fits               ? w_shifted[P-1:0] :
                     w_shifted[4*P-1]     ? {1'b1, {(P-1){1'b0}}} :
                                            {1'b0, {(P-1){1'b1}}};

endmodule
`default_nettype wire

// File: rtl/matmul_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : matmul_result_drain
// Description : Captures an M x N matrix of signed 4*P-bit accumulators on a
//               valid/ready handshake and streams it out one row per beat
//               with a last flag on row M-1. Back-to-back capture on the last
//               beat keeps the output bus bubble-free.
//               Optional macro MMA_DRAIN_SAT_EN: rows are shifted by SHIFT and
//               saturated to P bits on the way out.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_result_drain
    import mma_pkg::*;
#(
    parameter int M     = c_m,
    parameter int N     = c_n,
    parameter int P     = c_p,
    parameter int SHIFT = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic signed [4*P-1:0]             in_data_i [M][N],
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
`ifdef MMA_DRAIN_SAT_EN
    output logic signed [P-1:0]               out_data_o [N],
`else
    output logic signed [4*P-1:0]             out_data_o [N],
`endif
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row_o,
    output logic                              out_last_o,
    output logic                              busy_o
);

    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam logic [RW-1:0] c_row_max = RW'(M - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         w_row_nxt;
    logic signed [4*P-1:0] r_hold [M][N];
    logic signed [4*P-1:0] w_row_data [N];

    logic w_last;
    logic w_beat;
    logic w_capture;

    assign w_last    = (r_row == c_row_max);
    assign w_beat    = (r_state == c_drain) && out_ready_i;

    // A new matrix may enter while idle, or on the final beat of a drain
    // so the next matrix follows without a bubble.
    assign in_ready_o = (r_state == c_idle) ||
                        ((r_state == c_drain) && w_last && out_ready_i);
    assign w_capture  = in_valid_i && in_ready_o;

    assign out_valid_o = (r_state == c_drain);
    assign out_row_o   = r_row;
    assign out_last_o  = (r_state == c_drain) && w_last;
    assign busy_o      = (r_state == c_drain);

    // State and row counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_idle;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Next state: capture restarts at row 0, beats advance or finish the drain
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        if (w_capture) begin
            w_state_nxt = c_drain;
            w_row_nxt   = '0;
        end else if (w_beat) begin
            if (w_last) begin
                w_state_nxt = c_idle;
                w_row_nxt   = '0;
            end else begin
                w_row_nxt = r_row + 1'b1;
            end
        end
    end

    // Holding register loads only on an input handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold <= '{default: '0};
        end else if (w_capture) begin
            r_hold <= in_data_i;
        end
    end

    // Row select; the bus reads zero whenever nothing is being drained
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_row_data[j] = '0;
        end
        if (r_state == c_drain) begin
            w_row_data = r_hold[r_row];
        end
    end

`ifdef MMA_DRAIN_SAT_EN
    for (genvar j = 0; j < N; j++) begin : g_sat
        mma_row_sat #(
            .P     (P),
            .SHIFT (SHIFT)
        ) u_row_sat (
            .i_value (w_row_data[j]),
            .o_value (out_data_o[j])
        );
    end
`else
    for (genvar j = 0; j < N; j++) begin : g_pass
        assign out_data_o[j] = w_row_data[j];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_result_drain
// Description : Self-checking bench for matmul_result_drain (M=4, N=2, P=8).
//               Expected rows are queued at each input handshake and a
//               monitor pops and compares them on every output beat.
//               Optional macro MMA_DRAIN_SAT_EN adds the saturation vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_result_drain;

    localparam int M     = 4;
    localparam int N     = 2;
    localparam int P     = 8;
    localparam int SHIFT = 0;
`ifdef MMA_DRAIN_SAT_EN
    localparam int OW = P;
`else
    localparam int OW = 4*P;
`endif

    typedef struct packed {
        logic [N-1:0][31:0] d;
        logic [7:0]         row;
        logic               last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [4*P-1:0] in_data [M][N];
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data [N];
    logic [1:0]           out_row;
    logic                 out_last;
    logic                 busy;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   beat_run = 0;
    int   max_run  = 0;

    matmul_result_drain #(
        .M     (M),
        .N     (N),
        .P     (P),
        .SHIFT (SHIFT)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_row_o   (out_row),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    // Free-running clock
    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed matrix k: element = k*16 + r*4 + c, odd columns negated
    task automatic load(input int k);
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                in_data[r][c] = (c % 2 == 1) ? -(k*16 + r*4 + c) : (k*16 + r*4 + c);
            end
        end
    endtask

    task automatic push_row(input int a, input int b, input int row);
        exp_t e;
        e.d[0] = a;
        e.d[1] = b;
        e.row  = 8'(row);
        e.last = (row == M-1);
        exp_q.push_back(e);
    endtask

    task automatic push_cur();
        for (int r = 0; r < M; r++) begin
            push_row(in_data[r][0], in_data[r][1], r);
        end
    endtask

    // Offer the matrix on in_data until accepted; returns out_last at capture
    task automatic send(input bit keep_valid, input bit auto_push, output bit last_at_cap);
        int g;
        g = 0;
        last_at_cap = 1'b0;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            chk("capture_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        last_at_cap = out_last;
        if (auto_push) push_cur();
        tick();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 200) begin
            tick();
            g++;
        end
        chk("drain_timeout", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_row"}, out_row, 0);
        chk({tag, "_out_data0"}, out_data[0], 0);
        chk({tag, "_out_data1"}, out_data[1], 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Monitor: every beat pops one expected row and compares it
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat_row", out_row, -1);
            end else begin
                e = exp_q.pop_front();
                chk("row_data0", out_data[0], $signed(e.d[0]));
                chk("row_data1", out_data[1], $signed(e.d[1]));
                chk("row_index", out_row, e.row);
                chk("row_last", out_last, e.last);
            end
            beat_run++;
            if (beat_run > max_run) max_run = beat_run;
        end else begin
            beat_run = 0;
        end
    end

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit l;
        int saved0, saved1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) in_data[r][c] = '0;

        // Reset state
        #12;
        chk_reset_vals("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single matrix with out_ready held high
        load(0);
        send(1'b0, 1'b1, l);
        chk("latency_valid", out_valid, 1);
        chk("latency_row", out_row, 0);
        tick(); tick(); tick();
        chk("last_row_flag", out_last, 1);
        chk("last_row_busy", busy, 1);
        tick();
        chk("busy_cleared", busy, 0);
        chk("idle_in_ready", in_ready, 1);

        // Backpressure on row 0 for five cycles
        out_ready = 1'b0;
        load(1);
        saved0 = in_data[0][0];
        saved1 = in_data[0][1];
        send(1'b0, 1'b1, l);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_row", out_row, 0);
            chk("bp_data0", out_data[0], saved0);
            chk("bp_data1", out_data[1], saved1);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();

        // Back-to-back matrices with in_valid held high
        beat_run = 0;
        max_run  = 0;
        load(2);
        send(1'b1, 1'b1, l);
        load(3);
        send(1'b0, 1'b1, l);
        chk("b2b_capture_on_last", l, 1);
        wait_idle();
        chk("b2b_consecutive_beats", max_run, 2*M);

        // Input changes while draining are ignored
        load(4);
        send(1'b0, 1'b1, l);
        load(6);
        wait_idle();

        // Reset asserted after row 0 has been delivered
        load(5);
        send(1'b0, 1'b1, l);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        load(6);
        send(1'b0, 1'b1, l);
        chk("post_rst_row", out_row, 0);
        wait_idle();

`ifdef MMA_DRAIN_SAT_EN
        // Saturation vectors, SHIFT = 0
        for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) in_data[r][c] = '0;
        in_data[0][0] = 300;
        in_data[0][1] = -300;
        in_data[1][0] = 127;
        in_data[1][1] = -5;
        push_row(127, -128, 0);
        push_row(127, -5, 1);
        push_row(0, 0, 2);
        push_row(0, 0, 3);
        send(1'b0, 1'b0, l);
        wait_idle();
`endif

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
